// File: rtl/azadi_wb_mailbox_if.sv
// Wishbone B4 classic bus between the Caravel management SoC (master) and the
// Azadi mailbox (slave). Signal names follow the Caravel wbs_* pin names.
interface azadi_wb_mailbox_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/azadi_wb_mailbox.sv
// Host register window into the Azadi SoC: host-to-SoC and SoC-to-host FIFOs,
// a 32-bit control word and a level interrupt toward the host.
module azadi_wb_mailbox #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  azadi_wb_mailbox_if.slave        wbs,
  output logic [31:0]              h2s_data_o,
  output logic                     h2s_valid_o,
  input  logic                     h2s_ready_i,
  input  logic [31:0]              s2h_data_i,
  input  logic                     s2h_valid_i,
  output logic                     s2h_ready_o,
  output logic [31:0]              ctrl_o,
  output logic                     irq_o
);

  localparam int unsigned AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]  DEPTH_CNT = 4'(FIFO_DEPTH);

  localparam logic [7:0] OFF_TXDATA = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_CTRL   = 8'h0C;
  localparam logic [7:0] OFF_IRQ_EN = 8'h10;

  logic [31:0]   h2s_mem [FIFO_DEPTH];
  logic [31:0]   s2h_mem [FIFO_DEPTH];
  logic [AW-1:0] h2s_wptr, h2s_rptr, s2h_wptr, s2h_rptr;
  logic [3:0]    h2s_cnt, s2h_cnt;
  logic          overflow, underflow, irq_en, irq_q, ack_q;
  logic [31:0]   ctrl, dat_q, rdata;

  logic       req, fire, is_wr, is_rd;
  logic [7:0] offset;
  logic       h2s_full, h2s_empty, s2h_full, s2h_empty;
  logic       h2s_push, h2s_pop, s2h_push, s2h_pop;
  logic       ovf_set, uf_set, status_wr;

  assign req    = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign fire   = req & ~ack_q;
  assign is_wr  = fire &  wbs.wbs_we_i;
  assign is_rd  = fire & ~wbs.wbs_we_i;
  assign offset = wbs.wbs_adr_i[7:0];

  assign h2s_full  = (h2s_cnt == DEPTH_CNT);
  assign h2s_empty = (h2s_cnt == 4'd0);
  assign s2h_full  = (s2h_cnt == DEPTH_CNT);
  assign s2h_empty = (s2h_cnt == 4'd0);

  // Full/empty are the start-of-cycle values, so a same-cycle pop never rescues
  // a push into a full FIFO (and vice versa).
  assign h2s_push  = is_wr & (offset == OFF_TXDATA) & ~h2s_full;
  assign ovf_set   = is_wr & (offset == OFF_TXDATA) &  h2s_full;
  assign h2s_pop   = h2s_ready_i & ~h2s_empty;
  assign s2h_push  = s2h_valid_i & ~s2h_full;
  assign s2h_pop   = is_rd & (offset == OFF_RXDATA) & ~s2h_empty;
  assign uf_set    = is_rd & (offset == OFF_RXDATA) &  s2h_empty;
  assign status_wr = is_wr & (offset == OFF_STATUS);

  // NOTE: every variable assigned here gets a default first, otherwise an
  // unlisted offset would hold its old value and infer a latch.
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_RXDATA: rdata = s2h_empty ? '0 : s2h_mem[s2h_rptr];
      OFF_STATUS: rdata = {16'h0, s2h_cnt, h2s_cnt, 2'b00, underflow, overflow,
                           s2h_empty, s2h_full, h2s_empty, h2s_full};
      OFF_CTRL:   rdata = ctrl;
      OFF_IRQ_EN: rdata = {31'h0, irq_en};
      default:    rdata = '0;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      h2s_wptr  <= '0;
      h2s_rptr  <= '0;
      h2s_cnt   <= '0;
      s2h_wptr  <= '0;
      s2h_rptr  <= '0;
      s2h_cnt   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      ctrl      <= '0;
      irq_en    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ack_q <= fire;
      dat_q <= is_rd ? rdata : '0;

      if (h2s_push) h2s_wptr <= h2s_wptr + 1'b1;
      if (h2s_pop)  h2s_rptr <= h2s_rptr + 1'b1;
      h2s_cnt <= h2s_cnt + 4'(h2s_push) - 4'(h2s_pop);

      if (s2h_push) s2h_wptr <= s2h_wptr + 1'b1;
      if (s2h_pop)  s2h_rptr <= s2h_rptr + 1'b1;
      s2h_cnt <= s2h_cnt + 4'(s2h_push) - 4'(s2h_pop);

      // A new event beats a simultaneous write-one-to-clear.
      if (ovf_set)                             overflow  <= 1'b1;
      else if (status_wr && wbs.wbs_dat_i[4])  overflow  <= 1'b0;
      if (uf_set)                              underflow <= 1'b1;
      else if (status_wr && wbs.wbs_dat_i[5])  underflow <= 1'b0;

      if (is_wr && offset == OFF_CTRL) begin
        for (int b = 0; b < 4; b++) begin
          if (wbs.wbs_sel_i[b]) ctrl[8*b +: 8] <= wbs.wbs_dat_i[8*b +: 8];
        end
      end
      if (is_wr && offset == OFF_IRQ_EN && wbs.wbs_sel_i[0]) irq_en <= wbs.wbs_dat_i[0];

      irq_q <= irq_en & ~s2h_empty;
    end
  end

  // NOTE: FIFO storage has no reset; the counts and pointers alone define which
  // entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk_i) begin
    if (h2s_push) h2s_mem[h2s_wptr] <= wbs.wbs_dat_i;
    if (s2h_push) s2h_mem[s2h_wptr] <= s2h_data_i;
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign h2s_data_o    = h2s_mem[h2s_rptr];
  assign h2s_valid_o   = ~h2s_empty;
  assign s2h_ready_o   = ~s2h_full;
  assign ctrl_o        = ctrl;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_azadi_wb_mailbox.sv
// Self-checking bench for azadi_wb_mailbox: queue-based models of both FIFOs and
// of the expected read data, compared as the DUT acknowledges or pops.
module tb_azadi_wb_mailbox;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] h2s_data_o;
  logic        h2s_valid_o;
  logic        h2s_ready_i;
  logic [31:0] s2h_data_i;
  logic        s2h_valid_i;
  logic        s2h_ready_o;
  logic [31:0] ctrl_o;
  logic        irq_o;

  always #5 clk_i = ~clk_i;

  azadi_wb_mailbox_if bus ();

  azadi_wb_mailbox #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wbs         (bus),
    .h2s_data_o  (h2s_data_o),
    .h2s_valid_o (h2s_valid_o),
    .h2s_ready_i (h2s_ready_i),
    .s2h_data_i  (s2h_data_i),
    .s2h_valid_i (s2h_valid_i),
    .s2h_ready_o (s2h_ready_o),
    .ctrl_o      (ctrl_o),
    .irq_o       (irq_o)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          h2s_pops = 0;
  logic [31:0] h2s_model [$];
  logic [31:0] s2h_model [$];
  logic [31:0] rd_q      [$];
  logic        ovf_m = 1'b0;
  logic        uf_m  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_exp();
    logic [3:0] hc;
    logic [3:0] sc;
    hc = 4'(h2s_model.size());
    sc = 4'(s2h_model.size());
    return {16'h0, sc, hc, 2'b00, uf_m, ovf_m,
            sc == 4'd0, sc == 4'(DEPTH), hc == 4'd0, hc == 4'(DEPTH)};
  endfunction

  task automatic sync();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
  endtask

  // Called just after a rising edge; drives one access and waits a bounded time for ack.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input bit exp_ack, input string tag);
    int          lat;
    bit          acked;
    logic [31:0] e;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    lat   = 0;
    acked = 1'b0;
    for (int i = 1; i <= 8 && !acked; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (bus.wbs_ack_o) begin
        acked = 1'b1;
        lat   = i;
        if (!we) begin
          e = '0;
          if (rd_q.size() != 0) e = rd_q.pop_front();
          check({tag, "_rdata"}, bus.wbs_dat_o, e);
        end
      end
    end
    sync();
    bus_idle();
    if (exp_ack) check({tag, "_ack_latency"}, 32'(lat), 32'd1);
    else         check({tag, "_unexpected_ack"}, 32'(acked), 32'd0);
    @(negedge clk_i);
    check({tag, "_ack_pulse"}, 32'(bus.wbs_ack_o), 32'd0);
    check({tag, "_dat_idle"}, bus.wbs_dat_o, 32'd0);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input string tag);
    wb_xfer(1'b1, adr, dat, sel, 1'b1, tag);
  endtask

  task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    rd_q.push_back(exp);
    wb_xfer(1'b0, adr, 32'h0, 4'hF, 1'b1, tag);
  endtask

  task automatic host_tx(input logic [31:0] w, input string tag);
    if (h2s_model.size() < DEPTH) h2s_model.push_back(w);
    else                          ovf_m = 1'b1;
    wb_write(BASE + 32'h0, w, 4'hF, tag);
  endtask

  task automatic host_rx(input string tag);
    logic [31:0] e;
    e = '0;
    if (s2h_model.size() != 0) e = s2h_model.pop_front();
    else                       uf_m = 1'b1;
    wb_read(BASE + 32'h4, e, tag);
  endtask

  task automatic soc_push(input logic [31:0] w);
    s2h_data_i  = w;
    s2h_valid_i = 1'b1;
    @(negedge clk_i);
    if (s2h_ready_o) s2h_model.push_back(w);
    sync();
    s2h_valid_i = 1'b0;
  endtask

  task automatic drain_h2s(input string tag);
    h2s_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      if (!h2s_valid_o) break;
    end
    check({tag, "_valid_low"}, 32'(h2s_valid_o), 32'd0);
    check({tag, "_model_empty"}, 32'(h2s_model.size()), 32'd0);
    sync();
    h2s_ready_i = 1'b0;
  endtask

  // SoC-side consumer: each pop must deliver the oldest word the host queued.
  always @(negedge clk_i) begin
    if (rst_ni && h2s_valid_o && h2s_ready_i) begin
      if (h2s_model.size() == 0) check("h2s_pop_when_empty", 32'(h2s_valid_o), 32'd0);
      else                       check("h2s_data", h2s_data_o, h2s_model.pop_front());
      h2s_pops++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops0;
    bus_idle();
    h2s_ready_i = 1'b0;
    s2h_valid_i = 1'b0;
    s2h_data_i  = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Reset asserted in the middle of a CTRL write: the access must vanish.
    sync();
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_adr_i = BASE + 32'hC;
    bus.wbs_dat_i = 32'hFFFF_FFFF;
    bus.wbs_sel_i = 4'hF;
    #2 rst_ni = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      check("rst_no_ack", 32'(bus.wbs_ack_o), 32'd0);
    end
    bus_idle();
    sync();
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_dat_o", bus.wbs_dat_o, 32'd0);
    check("rst_ctrl_o", ctrl_o, 32'd0);
    check("rst_h2s_valid", 32'(h2s_valid_o), 32'd0);
    check("rst_s2h_ready", 32'(s2h_ready_o), 32'd1);
    check("rst_irq", 32'(irq_o), 32'd0);
    sync(); wb_read(BASE + 32'h8, 32'h0000_000A, "rst_status");

    // Byte-enabled CTRL write, unmapped and write-only offsets.
    sync(); wb_write(BASE + 32'hC, 32'hA5A5_1234, 4'b0101, "ctrl_wr");
    check("ctrl_o", ctrl_o, 32'h00A5_0034);
    sync(); wb_read(BASE + 32'hC, 32'h00A5_0034, "ctrl_rd");
    sync(); wb_write(BASE + 32'h24, 32'hFFFF_FFFF, 4'hF, "unmapped_wr");
    sync(); wb_read(BASE + 32'h24, 32'h0, "unmapped_rd");
    sync(); wb_read(BASE + 32'h0, 32'h0, "txdata_rd");
    check("ctrl_o_kept", ctrl_o, 32'h00A5_0034);

    // Overfill the host-to-SoC FIFO with the SoC stalled, then drain it.
    for (int w = 1; w <= 5; w++) begin
      sync(); host_tx(32'(w), "tx_fill");
    end
    check("h2s_head", h2s_data_o, 32'd1);
    sync(); wb_read(BASE + 32'h8, 32'h0000_0419, "status_ovf");
    pops0 = h2s_pops;
    drain_h2s("h2s_drain");
    check("h2s_pop_count", 32'(h2s_pops - pops0), 32'd4);

    // SoC-to-host word raises the interrupt one cycle later; underflow on empty read.
    sync(); wb_write(BASE + 32'h10, 32'hFFFF_FFFF, 4'b0001, "irqen_wr");
    sync(); wb_read(BASE + 32'h10, 32'h1, "irqen_rd");
    check("irq_idle", 32'(irq_o), 32'd0);
    sync(); soc_push(32'hDEAD_BEEF);
    @(negedge clk_i);
    check("irq_delay", 32'(irq_o), 32'd0);
    @(negedge clk_i);
    check("irq_set", 32'(irq_o), 32'd1);
    sync(); host_rx("rx_beef");
    check("irq_clear", 32'(irq_o), 32'd0);
    sync(); host_rx("rx_empty");
    sync(); wb_read(BASE + 32'h8, 32'h0000_003A, "status_flags");
    sync(); wb_write(BASE + 32'h8, 32'h30, 4'hF, "w1c");
    ovf_m = 1'b0;
    uf_m  = 1'b0;
    sync(); wb_read(BASE + 32'h8, 32'h0000_000A, "status_cleared");

    // Host push and SoC pop in the same cycle at count 2.
    sync(); host_tx(32'h5000_0001, "tx_a");
    sync(); host_tx(32'h5000_0002, "tx_b");
    sync();
    h2s_ready_i = 1'b1;
    fork
      host_tx(32'h5000_0003, "tx_simul");
      begin sync(); h2s_ready_i = 1'b0; end
    join
    check("h2s_head_after_simul", h2s_data_o, 32'h5000_0002);
    sync(); wb_read(BASE + 32'h8, status_exp(), "status_simul_cnt2");
    drain_h2s("h2s_drain2");

    // Fill SoC-to-host, reject a push while full, then stream with concurrent pops.
    for (int i = 0; i < 4; i++) begin
      sync(); soc_push(32'hC000_0000 + 32'(i));
    end
    @(negedge clk_i);
    check("s2h_ready_full", 32'(s2h_ready_o), 32'd0);
    sync(); soc_push(32'hBAD0_0000);
    sync(); wb_read(BASE + 32'h8, status_exp(), "status_s2h_full");
    sync(); host_rx("rx_stream");
    check("s2h_ready_after_pop", 32'(s2h_ready_o), 32'd1);
    for (int i = 4; i < 10; i++) begin
      sync();
      fork
        host_rx("rx_simul");
        soc_push(32'hC000_0000 + 32'(i));
      join
    end
    sync(); wb_read(BASE + 32'h8, status_exp(), "status_s2h_cnt3");

    // Out-of-window address and stb low are never acknowledged.
    sync(); wb_xfer(1'b1, BASE + 32'h100, 32'h1234_5678, 4'hF, 1'b0, "oob_wr");
    check("oob_no_push", 32'(h2s_valid_o), 32'd0);
    sync();
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_adr_i = BASE;
    bus.wbs_dat_i = 32'h8765_4321;
    bus.wbs_sel_i = 4'hF;
    repeat (4) begin
      @(negedge clk_i);
      check("stb_low_no_ack", 32'(bus.wbs_ack_o), 32'd0);
    end
    sync(); bus_idle();
    check("stb_low_no_push", 32'(h2s_valid_o), 32'd0);

    // Held request on RXDATA: ack toggles and each ack pops exactly one word.
    sync();
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = BASE + 32'h4;
    bus.wbs_sel_i = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check("held_ack", 32'(bus.wbs_ack_o), 32'(k % 2 == 0));
      if (bus.wbs_ack_o && s2h_model.size() != 0)
        check("held_rdata", bus.wbs_dat_o, s2h_model.pop_front());
    end
    sync(); bus_idle();
    sync(); wb_read(BASE + 32'h8, 32'h0000_000A, "status_final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
